// File: rtl/scrypt_romix_ctl.sv
// scrypt ROMix sequencer: writes N X-blocks to the scratchpad, then reads V[j] back and feeds the mixer.
// Latency: N*11 + 2N*core_latency + 2 cycles per ROMix; the RAM read has one cycle of latency.
// Backpressure: none on the RAM side; waits for a single-cycle x_valid from the core after each mix_go.
// Ports:
//   clock/reset_n        rising-edge clock, async active-low reset
//   start, x_in          launch one ROMix with initial X (start only seen in IDLE)
//   x_valid              core result strobe; x_in carries the new X
//   mix_go, mix_xor      one-cycle mix request, optionally XORing v_out into X first
//   v_out                V[j] assembled from four RAM words
//   ram_waddr/wdata/wren RAM write port; ram_raddr/ram_q RAM read port (registered address)
//   busy, done           state != IDLE; one-cycle completion pulse
module scrypt_romix_ctl #(
  parameter int NBITS    = 10,
  parameter int ADDRBITS = 12
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1023:0]       x_in,
  input  logic                x_valid,
  output logic                mix_go,
  output logic                mix_xor,
  output logic [1023:0]       v_out,
  output logic [ADDRBITS-1:0] ram_waddr,
  output logic [255:0]        ram_wdata,
  output logic                ram_wren,
  output logic [ADDRBITS-1:0] ram_raddr,
  input  logic [255:0]        ram_q,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WMIX = 3'd2,
    S_RD   = 3'd3,
    S_RMIX = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [3:0][255:0] xr;
  logic [3:0][255:0] vbuf;
  logic [NBITS-1:0]  i;
  logic [NBITS-1:0]  jr;
  logic [2:0]        sub;

  // sub==0 marks the first cycle of every state that uses it; in the mix
  // states that is the mix_go cycle, where x_valid is not yet legal.
  logic             first;
  logic             last_i;
  logic [NBITS-1:0] j_new;

  assign first  = (sub == 3'd0);
  assign last_i = &i;
  // Integerify: low NBITS bits of word 16 are already j mod N.
  assign j_new  = x_in[512 +: NBITS];

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_WR;
      S_WR:   if (sub == 3'd3) state_nxt = S_WMIX;
      S_WMIX: if (!first && x_valid) state_nxt = last_i ? S_RD : S_WR;
      S_RD:   if (sub == 3'd4) state_nxt = S_RMIX;
      S_RMIX: if (!first && x_valid) state_nxt = last_i ? S_DONE : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xr   <= '0;
      vbuf <= '0;
      i    <= '0;
      jr   <= '0;
      sub  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            xr  <= x_in;
            i   <= '0;
            sub <= '0;
          end
        end
        S_WR: sub <= (sub == 3'd3) ? 3'd0 : sub + 3'd1;
        S_WMIX: begin
          if (first) begin
            sub <= 3'd1;
          end else if (x_valid) begin
            xr  <= x_in;
            sub <= 3'd0;
            if (last_i) begin
              i  <= '0;
              jr <= j_new;
            end else begin
              i  <= i + 1'b1;
            end
          end
        end
        S_RD: begin
          // q lags the address by one cycle, so word sub-1 lands while sub is presented.
          if (!first) vbuf[sub[1:0] - 2'd1] <= ram_q;
          sub <= (sub == 3'd4) ? 3'd0 : sub + 3'd1;
        end
        S_RMIX: begin
          if (first) begin
            sub <= 3'd1;
          end else if (x_valid) begin
            xr  <= x_in;
            sub <= 3'd0;
            if (!last_i) begin
              i  <= i + 1'b1;
              jr <= j_new;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mix_go    = 1'b0;
    mix_xor   = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    ram_raddr = '0;
    case (state)
      S_WR: begin
        ram_wren  = 1'b1;
        ram_waddr = {i, sub[1:0]};
        ram_wdata = xr[sub[1:0]];
      end
      S_WMIX: mix_go = first;
      S_RD: begin
        if (sub != 3'd4) ram_raddr = {jr, sub[1:0]};
      end
      S_RMIX: begin
        mix_go  = first;
        mix_xor = first;
      end
      default: ;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign v_out = vbuf;

endmodule

// File: tb/tb_scrypt_romix_ctl.sv
// Bench for scrypt_romix_ctl: a small (N=4) and a default (N=1024) instance, each with a RAM and core model.
// Latency: core model answers two cycles after mix_go.
// Backpressure: none; the core model is the only source of x_valid.
module tb_scrypt_romix_ctl;

  localparam int NB_S = 2;
  localparam int N_S  = 4;
  localparam int N_B  = 1024;
  localparam int LAT  = 2;

  logic clock;
  logic reset_n;

  // small instance
  logic          start_s, x_valid_s, mix_go_s, mix_xor_s, ram_wren_s, busy_s, done_s;
  logic [1023:0] x_in_s, v_out_s;
  logic [3:0]    ram_waddr_s, ram_raddr_s;
  logic [255:0]  ram_wdata_s, ram_q_s;
  logic [255:0]  mem_s [16];

  // default instance
  logic          start_b, x_valid_b, mix_go_b, mix_xor_b, ram_wren_b, busy_b, done_b;
  logic [1023:0] x_in_b, v_out_b;
  logic [11:0]   ram_waddr_b, ram_raddr_b;
  logic [255:0]  ram_wdata_b, ram_q_b;
  logic [255:0]  mem_b [4096];

  int errors;
  int checks;

  scrypt_romix_ctl #(.NBITS(NB_S), .ADDRBITS(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start_s), .x_in(x_in_s), .x_valid(x_valid_s),
    .mix_go(mix_go_s), .mix_xor(mix_xor_s), .v_out(v_out_s),
    .ram_waddr(ram_waddr_s), .ram_wdata(ram_wdata_s), .ram_wren(ram_wren_s),
    .ram_raddr(ram_raddr_s), .ram_q(ram_q_s), .busy(busy_s), .done(done_s));

  scrypt_romix_ctl dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .x_in(x_in_b), .x_valid(x_valid_b),
    .mix_go(mix_go_b), .mix_xor(mix_xor_b), .v_out(v_out_b),
    .ram_waddr(ram_waddr_b), .ram_wdata(ram_wdata_b), .ram_wren(ram_wren_b),
    .ram_raddr(ram_raddr_b), .ram_q(ram_q_b), .busy(busy_b), .done(done_b));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (ram_wren_s) mem_s[ram_waddr_s] <= ram_wdata_s;
    ram_q_s <= mem_s[ram_raddr_s];
    if (ram_wren_b) mem_b[ram_waddr_b] <= ram_wdata_b;
    ram_q_b <= mem_b[ram_raddr_b];
  end

  // scoreboards
  int            sq_waddr [$];
  logic [255:0]  sq_wdata [$];
  int            sq_raddr [$];
  bit            sq_xor   [$];
  logic [1023:0] sq_v     [$];
  bit            bq_xor   [$];
  logic [1023:0] bq_v     [$];
  logic [1023:0] vmem     [1024];

  // core model / monitor state
  logic [1023:0] core_x_s, pend_s, core_x_b, pend_b;
  int  cnt_s, cnt_b, rd_win_s, mixes_s, mixes_b, deliv_s, deliv_b, dones_s, dones_b;
  int  busy_cyc_s, busy_cyc_b;
  bit  bad_s;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] salsa8(input logic [511:0] b);
    logic [31:0]  x [16];
    logic [31:0]  z [16];
    logic [511:0] o;
    int qi [8][4];
    qi = '{'{0,4,8,12}, '{5,9,13,1}, '{10,14,2,6}, '{15,3,7,11},
           '{0,1,2,3},  '{5,6,7,4},  '{10,11,8,9}, '{15,12,13,14}};
    for (int k = 0; k < 16; k++) begin
      x[k] = b[32*k +: 32];
      z[k] = x[k];
    end
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < 8; q++) begin
        z[qi[q][1]] ^= rotl(z[qi[q][0]] + z[qi[q][3]], 7);
        z[qi[q][2]] ^= rotl(z[qi[q][1]] + z[qi[q][0]], 9);
        z[qi[q][3]] ^= rotl(z[qi[q][2]] + z[qi[q][1]], 13);
        z[qi[q][0]] ^= rotl(z[qi[q][3]] + z[qi[q][2]], 18);
      end
    end
    for (int k = 0; k < 16; k++) o[32*k +: 32] = z[k] + x[k];
    return o;
  endfunction

  // BlockMix with r=1: Y0 = salsa(B1^B0), Y1 = salsa(Y0^B1), output Y0||Y1
  function automatic logic [1023:0] h_big(input logic [1023:0] xx);
    logic [511:0] y0, y1;
    y0 = salsa8(xx[1023:512] ^ xx[511:0]);
    y1 = salsa8(y0 ^ xx[1023:512]);
    return {y1, y0};
  endfunction

  function automatic logic [1023:0] h_small(input logic [1023:0] xx);
    logic [1023:0] y;
    for (int k = 0; k < 32; k++) y[32*k +: 32] = xx[32*k +: 32] + 32'd1;
    return y;
  endfunction

  // Software ROMix: fills the scoreboards with everything the DUT must produce.
  task automatic build_expect(input bit big, input logic [1023:0] x0, input int nb);
    logic [1023:0] x;
    int n, j;
    n = 1 << nb;
    x = x0;
    for (int k = 0; k < n; k++) begin
      vmem[k] = x;
      if (big) bq_xor.push_back(1'b0);
      else begin
        sq_xor.push_back(1'b0);
        for (int s = 0; s < 4; s++) begin
          sq_waddr.push_back(k*4 + s);
          sq_wdata.push_back(x[256*s +: 256]);
        end
      end
      x = big ? h_big(x) : h_small(x);
    end
    for (int k = 0; k < n; k++) begin
      j = int'(x[512 +: 32]) & (n - 1);
      if (big) begin
        bq_xor.push_back(1'b1);
        bq_v.push_back(vmem[j]);
      end else begin
        sq_xor.push_back(1'b1);
        sq_v.push_back(vmem[j]);
        for (int s = 0; s < 4; s++) sq_raddr.push_back(j*4 + s);
      end
      x = big ? h_big(x ^ vmem[j]) : h_small(x ^ vmem[j]);
    end
  endtask

  task automatic clear_s();
    sq_waddr.delete(); sq_wdata.delete(); sq_raddr.delete(); sq_xor.delete(); sq_v.delete();
    cnt_s = 0; rd_win_s = 0; mixes_s = 0; deliv_s = 0; dones_s = 0; busy_cyc_s = 0; bad_s = 1'b0;
  endtask

  task automatic tick_s();
    int ea;
    logic [255:0] ed;
    bit ex;
    logic [1023:0] ev;
    if (rd_win_s > 0) begin
      rd_win_s--;
      checks++;
      if (sq_raddr.size() == 0) begin
        errors++; $display("FAIL raddr_s: got %0d, no read expected", ram_raddr_s);
      end else begin
        ea = sq_raddr.pop_front();
        if (int'(ram_raddr_s) !== ea) begin
          errors++; $display("FAIL raddr_s: got %0d want %0d", ram_raddr_s, ea);
        end
      end
    end
    if (ram_wren_s) begin
      checks++;
      if (sq_waddr.size() == 0) begin
        errors++; $display("FAIL stray_wren_s: wren at addr %0d, no write expected", ram_waddr_s);
      end else begin
        ea = sq_waddr.pop_front();
        ed = sq_wdata.pop_front();
        if (int'(ram_waddr_s) !== ea || ram_wdata_s !== ed) begin
          errors++;
          $display("FAIL write_s: got addr %0d data %h want addr %0d data %h", ram_waddr_s, ram_wdata_s, ea, ed);
        end
      end
    end
    if (mix_go_s) begin
      mixes_s++;
      checks++;
      if (sq_xor.size() == 0) begin
        errors++; $display("FAIL mix_s: mix_go #%0d not expected", mixes_s);
      end else begin
        ex = sq_xor.pop_front();
        if (mix_xor_s !== ex) begin
          errors++; $display("FAIL mix_xor_s: mix %0d got %0b want %0b", mixes_s, mix_xor_s, ex);
        end
        if (ex) begin
          ev = sq_v.pop_front();
          checks++;
          if (v_out_s !== ev) begin
            errors++;
            $display("FAIL v_out_s: mix %0d got w16=%h w0=%h want w16=%h w0=%h",
                     mixes_s, v_out_s[543:512], v_out_s[31:0], ev[543:512], ev[31:0]);
          end
        end
      end
    end
    if (done_s) dones_s++;
    if (busy_s) busy_cyc_s++;
    // core model
    x_valid_s = 1'b0;
    if (cnt_s > 0) begin
      cnt_s--;
      if (cnt_s == 0) begin
        x_valid_s = 1'b1;
        core_x_s  = pend_s;
        deliv_s++;
        if (deliv_s >= N_S && deliv_s < 2*N_S) rd_win_s = 4;
      end
    end
    x_in_s = core_x_s;
    if (mix_go_s) begin
      pend_s = h_small(mix_xor_s ? (core_x_s ^ v_out_s) : core_x_s);
      cnt_s  = LAT;
      if (bad_s) begin
        bad_s     = 1'b0;
        x_valid_s = 1'b1;
        x_in_s    = ~core_x_s;
      end
    end
  endtask

  task automatic tick_b();
    bit ex;
    logic [1023:0] ev;
    if (mix_go_b) begin
      mixes_b++;
      checks++;
      if (bq_xor.size() == 0) begin
        errors++; $display("FAIL mix_b: mix_go #%0d not expected", mixes_b);
      end else begin
        ex = bq_xor.pop_front();
        if (mix_xor_b !== ex) begin
          errors++; $display("FAIL mix_xor_b: mix %0d got %0b want %0b", mixes_b, mix_xor_b, ex);
        end
        if (ex) begin
          ev = bq_v.pop_front();
          checks++;
          if (v_out_b !== ev) begin
            errors++;
            $display("FAIL v_out_b: mix %0d got w16=%h w0=%h want w16=%h w0=%h",
                     mixes_b, v_out_b[543:512], v_out_b[31:0], ev[543:512], ev[31:0]);
          end
        end
      end
    end
    if (done_b) dones_b++;
    if (busy_b) busy_cyc_b++;
    x_valid_b = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin
        x_valid_b = 1'b1;
        core_x_b  = pend_b;
        deliv_b++;
      end
    end
    x_in_b = core_x_b;
    if (mix_go_b) begin
      pend_b = h_big(mix_xor_b ? (core_x_b ^ v_out_b) : core_x_b);
      cnt_b  = LAT;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    tick_s();
    tick_b();
  endtask

  task automatic run_small(input string name, input logic [1023:0] x0, input bit bad, input int start_at);
    int t;
    clear_s();
    bad_s = bad;
    build_expect(1'b0, x0, NB_S);
    core_x_s = x0;
    x_in_s   = x0;
    start_s  = 1'b1;
    tick();
    start_s  = 1'b0;
    t = 0;
    while (dones_s == 0 && t < 2000) begin
      start_s = (start_at > 0 && t >= start_at && t < start_at + 5);
      tick();
      t++;
    end
    start_s = 1'b0;
    repeat (3) tick();
    checks++;
    if (dones_s !== 1) begin errors++; $display("FAIL %s_done: got %0d pulses want 1", name, dones_s); end
    checks++;
    if (mixes_s !== 2*N_S) begin errors++; $display("FAIL %s_mixes: got %0d want %0d", name, mixes_s, 2*N_S); end
    checks++;
    if (busy_cyc_s !== N_S*(11 + 2*LAT) + 1) begin
      errors++; $display("FAIL %s_cycles: busy %0d want %0d", name, busy_cyc_s, N_S*(11 + 2*LAT) + 1);
    end
    checks++;
    if (sq_waddr.size() + sq_raddr.size() + sq_xor.size() !== 0) begin
      errors++; $display("FAIL %s_leftover: %0d expected events never seen", name,
                         sq_waddr.size() + sq_raddr.size() + sq_xor.size());
    end
  endtask

  function automatic logic [1023:0] pattern(input logic [31:0] w16, input logic [31:0] seed);
    logic [1023:0] x;
    for (int k = 0; k < 32; k++) x[32*k +: 32] = seed + 32'h0101_0101 * k;
    x[543:512] = w16;
    return x;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    start_s = 1'b1;
    start_b = 1'b1;
    repeat (3) tick();
    checks++; if (ram_wren_s !== 1'b0)  begin errors++; $display("FAIL rst_wren: got %b want 0", ram_wren_s); end
    checks++; if (ram_waddr_s !== 4'd0) begin errors++; $display("FAIL rst_waddr: got %h want 0", ram_waddr_s); end
    checks++; if (ram_wdata_s !== '0)   begin errors++; $display("FAIL rst_wdata: got %h want 0", ram_wdata_s); end
    checks++; if (ram_raddr_s !== 4'd0) begin errors++; $display("FAIL rst_raddr: got %h want 0", ram_raddr_s); end
    checks++; if (v_out_s !== '0)       begin errors++; $display("FAIL rst_v_out: got w0=%h want 0", v_out_s[31:0]); end
    checks++; if ({mix_go_s, mix_xor_s} !== 2'b00) begin errors++; $display("FAIL rst_mix: got %b want 00", {mix_go_s, mix_xor_s}); end
    checks++; if ({busy_s, done_s} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b want 00", {busy_s, done_s}); end
    checks++; if ({busy_b, ram_wren_b, mix_go_b} !== 3'b000) begin errors++; $display("FAIL rst_big: got %b want 000", {busy_b, ram_wren_b, mix_go_b}); end
    start_s = 1'b0;
    start_b = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", busy_s); end
  endtask

  task automatic test_small_run();
    run_small("small", pattern(32'h0, 32'h1000_0000), 1'b0, 0);
  endtask

  task automatic test_integerify();
    run_small("integerify", pattern(32'hFFFF_FFFF, 32'h2222_0000), 1'b0, 0);
  endtask

  task automatic test_protocol();
    run_small("protocol", pattern(32'h5, 32'h3333_0000), 1'b1, 20);
  endtask

  task automatic test_reset_mid();
    int t;
    // abort in WR
    clear_s();
    build_expect(1'b0, pattern(32'h1, 32'h4444_0000), NB_S);
    core_x_s = pattern(32'h1, 32'h4444_0000);
    x_in_s = core_x_s;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    checks++; if (ram_wren_s !== 1'b1) begin errors++; $display("FAIL midwr_pre: wren got %b want 1", ram_wren_s); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (ram_wren_s !== 1'b0) begin errors++; $display("FAIL midwr_wren: got %b want 0", ram_wren_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL midwr_busy: got %b want 0", busy_s); end
    clear_s();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    // abort in phase 2
    build_expect(1'b0, pattern(32'h2, 32'h5555_0000), NB_S);
    core_x_s = pattern(32'h2, 32'h5555_0000);
    x_in_s = core_x_s;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    t = 0;
    while (deliv_s < N_S + 1 && t < 500) begin tick(); t++; end
    checks++; if (deliv_s < N_S + 1) begin errors++; $display("FAIL midrd_reach: got %0d results want %0d", deliv_s, N_S + 1); end
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_s, ram_wren_s, mix_go_s, ram_raddr_s} !== 7'd0 || v_out_s !== '0) begin
      errors++; $display("FAIL midrd_outs: busy/wren/go/raddr %b v_out w0=%h want all 0",
                         {busy_s, ram_wren_s, mix_go_s, ram_raddr_s}, v_out_s[31:0]);
    end
    clear_s();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    run_small("restart", pattern(32'h7, 32'h6666_0000), 1'b0, 0);
  endtask

  task automatic test_default();
    logic [1023:0] x0;
    int t;
    for (int k = 0; k < 32; k++) x0[32*k +: 32] = $urandom;
    bq_xor.delete(); bq_v.delete();
    cnt_b = 0; mixes_b = 0; deliv_b = 0; dones_b = 0; busy_cyc_b = 0;
    build_expect(1'b1, x0, 10);
    core_x_b = x0;
    x_in_b = x0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    t = 0;
    while (dones_b == 0 && t < 20000) begin tick(); t++; end
    repeat (3) tick();
    checks++; if (dones_b !== 1) begin errors++; $display("FAIL big_done: got %0d pulses want 1", dones_b); end
    checks++; if (mixes_b !== 2*N_B) begin errors++; $display("FAIL big_mixes: got %0d want %0d", mixes_b, 2*N_B); end
    checks++;
    if (busy_cyc_b !== N_B*(11 + 2*LAT) + 1) begin
      errors++; $display("FAIL big_cycles: busy %0d want %0d", busy_cyc_b, N_B*(11 + 2*LAT) + 1);
    end
    checks++; if (bq_xor.size() !== 0) begin errors++; $display("FAIL big_leftover: %0d mixes never seen", bq_xor.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    start_s = 1'b0; x_in_s = '0; x_valid_s = 1'b0;
    start_b = 1'b0; x_in_b = '0; x_valid_b = 1'b0;
    core_x_s = '0; pend_s = '0; core_x_b = '0; pend_b = '0;
    cnt_b = 0; mixes_b = 0; deliv_b = 0; dones_b = 0; busy_cyc_b = 0;
    clear_s();
    test_reset();
    test_small_run();
    test_integerify();
    test_protocol();
    test_reset_mid();
    test_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scrypt_romix_ctl.md
# scrypt_romix_ctl

Sequencer for the scrypt ROMix loop that sits directly upstream of the 256-bit scratchpad RAM. It drives the RAM's read/write ports and handshakes with the salsa BlockMix core.
- **Phase 1 (write):** stores each 1024-bit X as four RAM words, then requests a mix.
- **Phase 2 (read):** computes j = Integerify(X) mod N, reads V[j] back, and hands it to the core for X ^= V[j]; mix.

## Interface
- NBITS, 10, log2 of scrypt N (N = 2^NBITS entries).
- ADDRBITS, 12, RAM address width; must equal NBITS+2 (four words per entry).
- clock  in  1  rising-edge clock, shared with the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin one ROMix; sampled only in IDLE; x_in holds the initial X.
- x_in  in  1024  X from the core; word k = bits [32k+31:32k].
- x_valid  in  1  one-cycle pulse: x_in holds a new BlockMix result.
- mix_go  out  1  one-cycle pulse: core runs one BlockMix.
- mix_xor  out  1  valid with mix_go: core XORs v_out into X before mixing.
- v_out  out  1024  V[j] assembled from four RAM words; stable throughout RMIX.
- ram_waddr  out  ADDRBITS  RAM write address.
- ram_wdata  out  256  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_raddr  out  ADDRBITS  RAM read address; RAM registers it, so q is valid the next cycle.
- ram_q  in  256  RAM read data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when ROMix completes.

## Operation
- Internal registers:
  - xr: 1024-bit X.
  - i: NBITS-bit iteration counter.
  - sub: 3-bit word counter.
  - jr: NBITS-bit read index.
  - vbuf: 4×256 read buffer.
- **IDLE:** on start, xr<=x_in, i<=0, sub<=0, go to WR. start is ignored outside IDLE.
- **WR:** four cycles, sub=0..3.
  - ram_wren=1, ram_waddr={i,sub[1:0]}, ram_wdata=xr[256*sub+255:256*sub].
  - After sub=3, go to WMIX.
- **WMIX:**
  - First cycle: mix_go=1, mix_xor=0.
  - Later cycles: wait for x_valid. x_valid in the mix_go cycle is a protocol violation and is ignored.
  - On x_valid: xr<=x_in.
    - If i==N-1: i<=0, jr<=x_in[512+NBITS-1:512], go to RD.
    - Else: i<=i+1, go to WR.
- **RD:** five cycles, sub=0..4.
  - For sub 0..3: ram_raddr={jr,sub[1:0]}.
  - For sub 1..4: vbuf[sub-1]<=ram_q.
  - After sub=4, go to RMIX.
- **RMIX:**
  - First cycle: mix_go=1, mix_xor=1; v_out=vbuf for the whole state.
  - On x_valid: xr<=x_in.
    - If i==N-1, go to DONE.
    - Else: i<=i+1, jr<=x_in[512+NBITS-1:512], go to RD.
- **DONE:** done=1 for one cycle, then IDLE. The final X stays in the core.
- Integerify uses only the low NBITS bits of word 16; upper bits are ignored. No modulo arithmetic is needed.
- i wraps only by explicit reset to 0 at the phase change; it never overflows.

## Timing
- Reset (async assert, sync release): state=IDLE and every output is 0, including ram_wren, ram_waddr, ram_raddr, ram_wdata, v_out, mix_go, mix_xor, busy and done. Counters and registers are also 0.
- Reset mid-operation: ram_wren drops immediately, RAM contents are left as-is, and the next start runs normally.
- start at edge T: WR occupies cycles T+1..T+4 and mix_go is high at T+5.
- Phase 1 iteration: 5 cycles plus core latency.
- Phase 2 iteration: 6 cycles plus core latency.
- Total cycles: N·11 + 2N·core latency + 2 (start cycle and DONE).
- Read-after-write: the last phase-1 write (entry N-1) completes before the first RD cycle, so j=N-1 returns fresh data.
- v_out changes only in RD cycles sub 1..4 and is stable from the first RMIX cycle until x_valid.
- Exactly 2N mix_go pulses per ROMix: N with mix_xor=0 followed by N with mix_xor=1.

## Test plan
- **Reset:** hold reset_n=0 with start=1 -> all outputs 0, busy=0. Assert reset_n=0 asynchronously mid-WR -> ram_wren=0 before the next edge.
- **Small run** (NBITS=2, ADDRBITS=4; core model returns x+1 two cycles after mix_go; initial X word16=0) -> waddr 0..15 in order, each X written as four words.
  - After the 4th x_valid, raddr sequence follows the model's word16 low 2 bits.
  - done after 8 mix_go pulses.
- **Integerify boundary:** X word16=0xFFFFFFFF, NBITS=2 -> raddr={3,0},{3,1},{3,2},{3,3}. v_out equals the last-written entry 3.
- **Protocol edges:** x_valid asserted in the mix_go cycle -> ignored, state unchanged. start pulsed while busy -> ignored, i unchanged.
- **Reset mid-phase-2,** then restart with new X -> full correct run; no stray wren after reset.
- **Default parameters,** golden scrypt(N=1024, r=1) software model -> all 1024 v_out values and mix_xor pattern match. done occurs exactly once after 2048 mix_go pulses.
